frame_buffer_writer: RTL and testbench



---
 rtl/frame_buffer_writer.sv | 181 ++++++++++++++++++
 tb/tb_frame_buffer_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_writer.sv
// Writer side of the frame BRAM. It turns a raster RGB444 pixel stream into BRAM writes at row*IMAGE_WIDTH+col.
// It also qualifies frames: SOF resync, long-line clipping, a sticky line error and a frame_done pulse.
module frame_buffer_writer #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture_en,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  input  logic                 pix_eol,
  input  logic [11:0]          pix_data,
  output logic [ADDR_BITS-1:0] wraddress,
  output logic [11:0]          wrdata,
  output logic                 wren,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 line_error,
  output logic [7:0]           frame_count,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(IMAGE_WIDTH + 1);
  localparam int RW = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [CW-1:0] C_W    = CW'(IMAGE_WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] R_H    = RW'(IMAGE_HEIGHT);
  localparam logic [RW-1:0] R_LAST = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_wren;
  logic [ADDR_BITS-1:0]  r_wraddr;
  logic [11:0]           r_wrdata;
  logic                  r_done;
  logic                  r_lerr;
  logic [7:0]            r_fcnt;

  state_t                w_state_n;
  logic [CW-1:0]         w_col_n;
  logic [RW-1:0]         w_row_n;
  logic [ADDR_BITS-1:0]  w_addr_n;
  logic                  w_wren_n;
  logic [ADDR_BITS-1:0]  w_wraddr_n;
  logic [11:0]           w_wrdata_n;
  logic                  w_done_n;
  logic                  w_lerr_n;
  logic [7:0]            w_fcnt_n;

  // Position seen by the current pixel, after any SOF resync on this same pixel.
  state_t                w_cur_state;
  logic [CW-1:0]         w_cur_col;
  logic [RW-1:0]         w_cur_row;
  logic [ADDR_BITS-1:0]  w_cur_addr;
  logic [CW-1:0]         w_rem;
  logic                  w_store;

  always_comb begin
    w_state_n   = r_state;
    w_col_n     = r_col;
    w_row_n     = r_row;
    w_addr_n    = r_addr;
    w_wren_n    = 1'b0;
    w_wraddr_n  = r_wraddr;
    w_wrdata_n  = r_wrdata;
    w_done_n    = 1'b0;
    w_lerr_n    = r_lerr;
    w_fcnt_n    = r_fcnt;
    w_cur_state = r_state;
    w_cur_col   = r_col;
    w_cur_row   = r_row;
    w_cur_addr  = r_addr;
    w_store     = 1'b0;

    if (pix_valid && pix_sof) begin
      w_cur_col   = '0;
      w_cur_row   = '0;
      w_cur_addr  = '0;
      w_cur_state = capture_en ? S_CAPTURE : S_DROP;
      if (capture_en) w_lerr_n = 1'b0;
    end

    // Distance to the next line start; col saturates at IMAGE_WIDTH, so clipped lines add 0.
    w_rem = C_W - w_cur_col;

    if (pix_valid) begin
      w_state_n = w_cur_state;
      w_col_n   = w_cur_col;
      w_row_n   = w_cur_row;
      w_addr_n  = w_cur_addr;
      case (w_cur_state)
        S_CAPTURE: begin
          w_store = (w_cur_col < C_W) && (w_cur_row < R_H);
          if (w_store) begin
            w_wren_n   = 1'b1;
            w_wraddr_n = w_cur_addr;
            w_wrdata_n = pix_data;
            w_col_n    = w_cur_col + CW'(1);
            w_addr_n   = w_cur_addr + ADDR_BITS'(1);
          end else begin
            w_lerr_n = 1'b1;
          end
          if (pix_eol) begin
            if (w_cur_col != C_LAST) w_lerr_n = 1'b1;
            if (w_cur_row == R_LAST) begin
              w_done_n  = 1'b1;
              w_fcnt_n  = r_fcnt + 8'd1;
              w_state_n = S_IDLE;
              w_col_n   = '0;
              w_row_n   = '0;
              w_addr_n  = '0;
            end else begin
              w_col_n  = '0;
              w_row_n  = w_cur_row + RW'(1);
              w_addr_n = w_cur_addr + ADDR_BITS'(w_rem);
            end
          end
        end
        S_DROP: begin
          if (pix_eol) begin
            if (w_cur_row == R_LAST) begin
              w_state_n = S_IDLE;
              w_row_n   = '0;
            end else begin
              w_row_n = w_cur_row + RW'(1);
            end
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_addr   <= '0;
      r_wren   <= 1'b0;
      r_wraddr <= '0;
      r_wrdata <= '0;
      r_done   <= 1'b0;
      r_lerr   <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_col    <= w_col_n;
      r_row    <= w_row_n;
      r_addr   <= w_addr_n;
      r_wren   <= w_wren_n;
      r_wraddr <= w_wraddr_n;
      r_wrdata <= w_wrdata_n;
      r_done   <= w_done_n;
      r_lerr   <= w_lerr_n;
      r_fcnt   <= w_fcnt_n;
    end
  end

  assign wren        = r_wren;
  assign wraddress   = r_wraddr;
  assign wrdata      = r_wrdata;
  assign frame_done  = r_done;
  assign line_error  = r_lerr;
  assign frame_count = r_fcnt;
  assign busy        = (r_state == S_CAPTURE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer on a reduced 20x12 frame.
// A reference model turns each driven pixel into expected BRAM writes, which are compared as they appear.
module tb_frame_buffer_writer;
  localparam int W  = 20;
  localparam int H  = 12;
  localparam int AB = $clog2(W*H);

  logic          clk;
  logic          reset;
  logic          capture_en;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_eol;
  logic [11:0]   pix_data;
  logic [AB-1:0] wraddress;
  logic [11:0]   wrdata;
  logic          wren;
  logic          busy;
  logic          frame_done;
  logic          line_error;
  logic [7:0]    frame_count;
  logic [1:0]    dbg_state;

  frame_buffer_writer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_data(pix_data),
    .wraddress(wraddress), .wrdata(wrdata), .wren(wren), .busy(busy),
    .frame_done(frame_done), .line_error(line_error), .frame_count(frame_count),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: {final_pixel_flag, addr, data} per expected write.
  logic [AB+12:0] exp_q[$];
  logic [11:0]    mem [2**AB];
  bit             m_cap;
  bit             m_lerr;
  int             m_row, m_col, m_fcnt;
  int             exp_wr, exp_done, got_wr, got_done, last_done_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  initial begin
    logic [AB+12:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wren) begin
          got_wr++;
          mem[wraddress] = wrdata;
          if (frame_done) begin
            got_done++;
            last_done_addr = int'(wraddress);
          end
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(wraddress), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wraddress), 32'(e[AB+11:12]));
            check("wr_data", 32'(wrdata), 32'(e[11:0]));
            check("wr_done", 32'(frame_done), 32'(e[AB+12]));
          end
        end else if (frame_done) begin
          got_done++;
          check("done_without_wren", 32'(frame_done), 32'd0);
        end
      end
    end
  end

  task automatic send_pix(input bit sof, input bit eol, input logic [11:0] d);
    if ($urandom_range(0, 4) == 0) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'($urandom_range(0, 1));
      pix_eol   = 1'($urandom_range(0, 1));
      pix_data  = 12'($urandom_range(0, 4095));
    end
    @(negedge clk);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_eol   = eol;
    pix_data  = d;
    if (sof) begin
      m_cap = capture_en;
      m_row = 0;
      m_col = 0;
      if (capture_en) m_lerr = 1'b0;
    end
    if (m_cap) begin
      if (m_col < W) begin
        exp_q.push_back({(eol && m_row == H-1), AB'(m_row*W + m_col), d});
        exp_wr++;
      end else begin
        m_lerr = 1'b1;
      end
      if (eol) begin
        if (m_col != W-1) m_lerr = 1'b1;
        if (m_row == H-1) begin
          m_cap = 1'b0;
          m_fcnt++;
          exp_done++;
        end else begin
          m_row++;
          m_col = 0;
        end
      end else if (m_col < W) begin
        m_col++;
      end
    end
  endtask

  task automatic send_line(input int row, input int len, input bit sof);
    for (int c = 0; c < len; c++)
      send_pix(sof && c == 0, c == len-1, {row[5:0], c[5:0]});
  endtask

  task automatic send_rows(input int first, input int last);
    for (int r = first; r <= last; r++) send_line(r, W, 1'b0);
  endtask

  task automatic drain();
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    #1;
  endtask

  task automatic check_end(input string tag);
    drain();
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_wren_count"}, 32'(got_wr), 32'(exp_wr));
    check({tag, "_done_count"}, 32'(got_done), 32'(exp_done));
    check({tag, "_frame_count"}, 32'(frame_count), 32'(m_fcnt & 255));
    check({tag, "_line_error"}, 32'(line_error), 32'(m_lerr));
    check({tag, "_busy"}, 32'(busy), 32'(m_cap));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; capture_en = 1'b0; pix_valid = 1'b0;
    pix_sof = 1'b0; pix_eol = 1'b0; pix_data = '0;
    m_cap = 0; m_lerr = 0; m_row = 0; m_col = 0; m_fcnt = 0;
    exp_wr = 0; exp_done = 0; got_wr = 0; got_done = 0; last_done_addr = -1;
    for (int i = 0; i < 2**AB; i++) mem[i] = 12'hFFF;
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_wraddress", 32'(wraddress), 32'd0);
    check("rst_wrdata", 32'(wrdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_line_error", 32'(line_error), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full well-formed frame.
    capture_en = 1'b1;
    send_line(0, W, 1'b1);
    send_rows(1, H-1);
    check_end("full");
    check("full_last_col_data", 32'(mem[W-1]), 32'h013);
    check("full_done_addr", 32'(last_done_addr), 32'(W*H-1));

    // Row 0 short: row 1 must still start at address W.
    send_line(0, 5, 1'b1);
    send_rows(1, H-1);
    check_end("short");
    check("short_row1_start", 32'(mem[W]), 32'h040);

    // Row 0 long: extra pixels are clipped.
    send_line(0, W+10, 1'b1);
    send_rows(1, H-1);
    check_end("long");
    check("long_row0_end", 32'(mem[W-1]), 32'h013);

    // One-pixel line (SOF and EOL together) then full rows.
    send_line(0, 1, 1'b1);
    send_rows(1, H-1);
    check_end("onepix");

    // Abort mid-frame by a new SOF, then a full frame.
    send_line(0, W, 1'b1);
    send_rows(1, 2);
    send_line(3, 7, 1'b0);
    drain();
    check("abort_busy_mid", 32'(busy), 32'd1);
    check("abort_state_mid", 32'(dbg_state), 32'd1);
    send_line(0, W, 1'b1);
    send_rows(1, H-1);
    check_end("abort");

    // Unarmed frame is dropped, next armed frame captures.
    capture_en = 1'b0;
    send_line(0, W, 1'b1);
    drain();
    check("drop_state", 32'(dbg_state), 32'd2);
    check("drop_busy", 32'(busy), 32'd0);
    send_rows(1, H-1);
    check_end("drop");
    capture_en = 1'b1;
    send_line(0, W, 1'b1);
    send_rows(1, H-1);
    check_end("rearm");

    // Reset mid-frame.
    send_line(0, W, 1'b1);
    send_rows(1, 3);
    drain();
    check("rst_mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_wren", 32'(wren), 32'd0);
    check("rst_mid_busy_low", 32'(busy), 32'd0);
    check("rst_mid_frame_count", 32'(frame_count), 32'd0);
    check("rst_mid_wraddress", 32'(wraddress), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    m_cap = 0; m_lerr = 0; m_fcnt = 0; m_row = 0; m_col = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    send_rows(4, 5);
    check_end("post_rst_nosof");
    send_line(0, W, 1'b1);
    send_rows(1, H-1);
    check_end("post_rst_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
